// File: rtl/lift_car_model.sv
`default_nettype none
// ============================================================================
//  Module      : lift_car_model
//  Description : Synthesisable plant model of a lift car, shaft and door.
//                Consumes motor/door level commands, advances the car
//                sub-position and door position with fixed travel times, and
//                returns floor, limit-switch, arrival and obstacle signals.
//                Optional macro LIFT_MODEL_FAULT_CHECK_EN enables the sticky
//                illegal-command flag on out_fault (tied 0 when undefined).
//  Revision    : 1.0  initial release
// ============================================================================
module lift_car_model #(
  parameter int NUM_FLOORS          = 11,
  parameter int FLOOR_W             = 4,
  parameter int FLOOR_TRAVEL_CYCLES = 16,
  parameter int DOOR_TRAVEL_CYCLES  = 8,
  parameter int START_FLOOR         = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_up_direction,
  input  logic               in_down_direction,
  input  logic               in_door_opening,
  input  logic               in_door_closing,
  input  logic               in_obstacle_inject,
  output logic [FLOOR_W-1:0] out_floor,
  output logic               out_at_floor,
  output logic               out_reached,
  output logic               out_door_open,
  output logic               out_door_closed,
  output logic               out_door_obstacle,
  output logic               out_fault
);

  localparam int SUB_W  = (FLOOR_TRAVEL_CYCLES > 1) ? $clog2(FLOOR_TRAVEL_CYCLES) : 1;
  localparam int DOOR_W = $clog2(DOOR_TRAVEL_CYCLES + 1);

  localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(FLOOR_TRAVEL_CYCLES - 1);
  localparam logic [SUB_W-1:0]   SUB_ONE    = SUB_W'(1);
  localparam logic [SUB_W-1:0]   SUB_ZERO   = '0;
  localparam logic [FLOOR_W-1:0] FLOOR_TOP  = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] FLOOR_BOT  = '0;
  localparam logic [FLOOR_W-1:0] FLOOR_INIT = FLOOR_W'(START_FLOOR);
  localparam logic [FLOOR_W-1:0] FLOOR_ONE  = FLOOR_W'(1);
  localparam logic [DOOR_W-1:0]  DOOR_FULL  = DOOR_W'(DOOR_TRAVEL_CYCLES);
  localparam logic [DOOR_W-1:0]  DOOR_ONE   = DOOR_W'(1);
  localparam logic [DOOR_W-1:0]  DOOR_SHUT  = '0;

  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [DOOR_W-1:0]  door_pos_q, door_pos_d;
  logic               reached_q, reached_d;
  logic               obstacle_q, obstacle_d;
  logic               fault_q, fault_d;

  logic at_floor;
  logic door_ajar;
  logic motion_cmd;
  logic door_cmd;
  logic illegal;

  assign at_floor   = (sub_q == SUB_ZERO);
  assign door_ajar  = (door_pos_q != DOOR_SHUT);
  assign motion_cmd = in_up_direction | in_down_direction;
  assign door_cmd   = in_door_opening | in_door_closing;

  // Any conflicting or unsafe command combination is rejected as a whole.
  always_comb begin
    illegal = 1'b0;
    if (in_up_direction && in_down_direction)                    illegal = 1'b1;
    if (in_door_opening && in_door_closing)                      illegal = 1'b1;
    if (motion_cmd && door_cmd)                                  illegal = 1'b1;
    if (motion_cmd && door_ajar)                                 illegal = 1'b1;
    if (door_cmd && !at_floor)                                   illegal = 1'b1;
    if (in_up_direction && floor_q == FLOOR_TOP && at_floor)     illegal = 1'b1;
    if (in_down_direction && floor_q == FLOOR_BOT && at_floor)   illegal = 1'b1;
  end

  // Next-state for car position, door position, arrival pulse and obstacle.
  always_comb begin
    floor_d    = floor_q;
    sub_d      = sub_q;
    door_pos_d = door_pos_q;
    reached_d  = 1'b0;
    obstacle_d = in_obstacle_inject & door_ajar;
    if (!illegal) begin
      if (in_up_direction) begin
        if (sub_q == SUB_LAST) begin
          floor_d   = floor_q + FLOOR_ONE;
          sub_d     = SUB_ZERO;
          reached_d = 1'b1;
        end else begin
          sub_d = sub_q + SUB_ONE;
        end
      end else if (in_down_direction) begin
        // Leaving a floor downward drops to the floor below at the top of
        // its travel window; arrival is flagged only when sub returns to 0.
        if (sub_q == SUB_ZERO) begin
          floor_d = floor_q - FLOOR_ONE;
          sub_d   = SUB_LAST;
        end else if (sub_q == SUB_ONE) begin
          sub_d     = SUB_ZERO;
          reached_d = 1'b1;
        end else begin
          sub_d = sub_q - SUB_ONE;
        end
      end else if (in_door_opening) begin
        if (door_pos_q != DOOR_FULL) door_pos_d = door_pos_q + DOOR_ONE;
      end else if (in_door_closing) begin
        // An object in the doorway stalls closing without raising a fault.
        if (door_ajar && !in_obstacle_inject) door_pos_d = door_pos_q - DOOR_ONE;
      end
    end
  end

`ifdef LIFT_MODEL_FAULT_CHECK_EN
  // Sticky flag: once any illegal command is seen it holds until reset.
  always_comb fault_d = fault_q | illegal;
`else
  // Fault reporting disabled; illegal commands are still ignored above.
  always_comb fault_d = 1'b0;
`endif

  // State register with synchronous active-low reset to the start floor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      floor_q    <= FLOOR_INIT;
      sub_q      <= SUB_ZERO;
      door_pos_q <= DOOR_SHUT;
      reached_q  <= 1'b0;
      obstacle_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      floor_q    <= floor_d;
      sub_q      <= sub_d;
      door_pos_q <= door_pos_d;
      reached_q  <= reached_d;
      obstacle_q <= obstacle_d;
      fault_q    <= fault_d;
    end
  end

  assign out_floor         = floor_q;
  assign out_at_floor      = at_floor;
  assign out_reached       = reached_q;
  assign out_door_open     = (door_pos_q == DOOR_FULL);
  assign out_door_closed   = (door_pos_q == DOOR_SHUT);
  assign out_door_obstacle = obstacle_q;
  assign out_fault         = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_lift_car_model.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lift_car_model
//  Description : Directed self-checking bench for lift_car_model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lift_car_model;

`ifdef LIFT_MODEL_FAULT_CHECK_EN
  localparam logic FAULT_EXP = 1'b1;
`else
  localparam logic FAULT_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up, dn, op, cl, obs;
  logic [3:0] floor;
  logic       at_floor, reached, door_open, door_closed, obstacle, fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lift_car_model dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_up_direction    (up),
    .in_down_direction  (dn),
    .in_door_opening    (op),
    .in_door_closing    (cl),
    .in_obstacle_inject (obs),
    .out_floor          (floor),
    .out_at_floor       (at_floor),
    .out_reached        (reached),
    .out_door_open      (door_open),
    .out_door_closed    (door_closed),
    .out_door_obstacle  (obstacle),
    .out_fault          (fault)
  );

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic u, input logic d, input logic o, input logic c, input logic ob);
    up = u; dn = d; op = o; cl = c; obs = ob;
  endtask

  task automatic do_reset();
    cmd(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (floor !== 4'd0)     begin n_err++; $display("FAIL reset_floor: got %0d expected %0d", floor, 0); end
    n_cmp++; if (at_floor !== 1'b1)  begin n_err++; $display("FAIL reset_at_floor: got %0b expected 1", at_floor); end
    n_cmp++; if (reached !== 1'b0)   begin n_err++; $display("FAIL reset_reached: got %0b expected 0", reached); end
    n_cmp++; if (door_open !== 1'b0) begin n_err++; $display("FAIL reset_door_open: got %0b expected 0", door_open); end
    n_cmp++; if (door_closed !== 1'b1) begin n_err++; $display("FAIL reset_door_closed: got %0b expected 1", door_closed); end
    n_cmp++; if (obstacle !== 1'b0)  begin n_err++; $display("FAIL reset_obstacle: got %0b expected 0", obstacle); end
    n_cmp++; if (fault !== 1'b0)     begin n_err++; $display("FAIL reset_fault: got %0b expected 0", fault); end
  endtask

  task automatic test_up_travel();
    do_reset();
    cmd(1, 0, 0, 0, 0);
    tick(15);
    n_cmp++; if (floor !== 4'd0)    begin n_err++; $display("FAIL up15_floor: got %0d expected 0", floor); end
    n_cmp++; if (at_floor !== 1'b0) begin n_err++; $display("FAIL up15_at_floor: got %0b expected 0", at_floor); end
    n_cmp++; if (reached !== 1'b0)  begin n_err++; $display("FAIL up15_reached: got %0b expected 0", reached); end
    tick(1);
    n_cmp++; if (floor !== 4'd1)    begin n_err++; $display("FAIL up16_floor: got %0d expected 1", floor); end
    n_cmp++; if (at_floor !== 1'b1) begin n_err++; $display("FAIL up16_at_floor: got %0b expected 1", at_floor); end
    n_cmp++; if (reached !== 1'b1)  begin n_err++; $display("FAIL up16_reached: got %0b expected 1", reached); end
    tick(1);
    n_cmp++; if (reached !== 1'b0)  begin n_err++; $display("FAIL up17_reached_pulse: got %0b expected 0", reached); end
    n_cmp++; if (fault !== 1'b0)    begin n_err++; $display("FAIL up_legal_fault: got %0b expected 0", fault); end
    tick(159);
    n_cmp++; if (floor !== 4'd10)   begin n_err++; $display("FAIL up_top_floor: got %0d expected 10", floor); end
    n_cmp++; if (at_floor !== 1'b1) begin n_err++; $display("FAIL up_top_at_floor: got %0b expected 1", at_floor); end
    n_cmp++; if (reached !== 1'b0)  begin n_err++; $display("FAIL up_top_reached: got %0b expected 0", reached); end
    n_cmp++; if (fault !== FAULT_EXP) begin n_err++; $display("FAIL up_top_fault: got %0b expected %0b", fault, FAULT_EXP); end
    cmd(0, 0, 0, 0, 0);
  endtask

  task automatic test_down_travel();
    do_reset();
    cmd(0, 1, 0, 0, 0);
    tick(3);
    n_cmp++; if (floor !== 4'd0 || at_floor !== 1'b1) begin n_err++; $display("FAIL down_at_bottom: got floor %0d at %0b expected 0 1", floor, at_floor); end
    n_cmp++; if (fault !== FAULT_EXP) begin n_err++; $display("FAIL down_at_bottom_fault: got %0b expected %0b", fault, FAULT_EXP); end
    do_reset();
    cmd(1, 0, 0, 0, 0);
    tick(16);
    cmd(0, 1, 0, 0, 0);
    tick(1);
    n_cmp++; if (floor !== 4'd0 || at_floor !== 1'b0) begin n_err++; $display("FAIL down1_pos: got floor %0d at %0b expected 0 0", floor, at_floor); end
    n_cmp++; if (reached !== 1'b0)  begin n_err++; $display("FAIL down1_reached: got %0b expected 0", reached); end
    tick(14);
    n_cmp++; if (at_floor !== 1'b0 || reached !== 1'b0) begin n_err++; $display("FAIL down15: got at %0b reached %0b expected 0 0", at_floor, reached); end
    tick(1);
    n_cmp++; if (floor !== 4'd0 || at_floor !== 1'b1 || reached !== 1'b1) begin n_err++; $display("FAIL down16: got floor %0d at %0b reached %0b expected 0 1 1", floor, at_floor, reached); end
    n_cmp++; if (fault !== 1'b0)    begin n_err++; $display("FAIL down_legal_fault: got %0b expected 0", fault); end
    cmd(0, 0, 0, 0, 0);
  endtask

  task automatic test_door();
    do_reset();
    cmd(1, 0, 0, 0, 0);
    tick(48);
    cmd(0, 0, 0, 0, 0);
    n_cmp++; if (floor !== 4'd3 || at_floor !== 1'b1) begin n_err++; $display("FAIL door_floor3: got floor %0d at %0b expected 3 1", floor, at_floor); end
    cmd(0, 0, 1, 0, 0);
    tick(1);
    n_cmp++; if (door_closed !== 1'b0 || door_open !== 1'b0) begin n_err++; $display("FAIL open1_limits: got open %0b closed %0b expected 0 0", door_open, door_closed); end
    tick(6);
    n_cmp++; if (door_open !== 1'b0) begin n_err++; $display("FAIL open7_open: got %0b expected 0", door_open); end
    tick(1);
    n_cmp++; if (door_open !== 1'b1 || door_closed !== 1'b0) begin n_err++; $display("FAIL open8_limits: got open %0b closed %0b expected 1 0", door_open, door_closed); end
    tick(2);
    n_cmp++; if (door_open !== 1'b1 || fault !== 1'b0) begin n_err++; $display("FAIL open_hold: got open %0b fault %0b expected 1 0", door_open, fault); end
    cmd(0, 0, 0, 1, 0);
    tick(7);
    n_cmp++; if (door_open !== 1'b0 || door_closed !== 1'b0) begin n_err++; $display("FAIL close7_limits: got open %0b closed %0b expected 0 0", door_open, door_closed); end
    tick(1);
    n_cmp++; if (door_closed !== 1'b1) begin n_err++; $display("FAIL close8_closed: got %0b expected 1", door_closed); end
    tick(2);
    n_cmp++; if (door_closed !== 1'b1 || fault !== 1'b0 || floor !== 4'd3) begin n_err++; $display("FAIL close_hold: got closed %0b fault %0b floor %0d expected 1 0 3", door_closed, fault, floor); end
    cmd(0, 0, 0, 0, 0);
  endtask

  task automatic test_obstacle();
    do_reset();
    cmd(0, 0, 0, 0, 1);
    tick(2);
    n_cmp++; if (obstacle !== 1'b0) begin n_err++; $display("FAIL obs_door_closed: got %0b expected 0", obstacle); end
    cmd(0, 0, 1, 0, 0);
    tick(5);
    cmd(0, 0, 0, 1, 1);
    tick(1);
    n_cmp++; if (obstacle !== 1'b1) begin n_err++; $display("FAIL obs_latency: got %0b expected 1", obstacle); end
    tick(3);
    n_cmp++; if (obstacle !== 1'b1 || door_closed !== 1'b0) begin n_err++; $display("FAIL obs_hold: got obs %0b closed %0b expected 1 0", obstacle, door_closed); end
    cmd(0, 0, 0, 1, 0);
    tick(1);
    n_cmp++; if (obstacle !== 1'b0) begin n_err++; $display("FAIL obs_release: got %0b expected 0", obstacle); end
    tick(3);
    n_cmp++; if (door_closed !== 1'b0) begin n_err++; $display("FAIL obs_close4: got %0b expected 0", door_closed); end
    tick(1);
    n_cmp++; if (door_closed !== 1'b1) begin n_err++; $display("FAIL obs_close5: got %0b expected 1", door_closed); end
    n_cmp++; if (fault !== 1'b0)       begin n_err++; $display("FAIL obs_fault: got %0b expected 0", fault); end
    cmd(0, 0, 0, 0, 0);
  endtask

  task automatic test_reversal();
    int pulses;
    do_reset();
    cmd(1, 0, 0, 0, 0);
    tick(32);
    tick(7);
    n_cmp++; if (floor !== 4'd2 || at_floor !== 1'b0) begin n_err++; $display("FAIL rev_up7: got floor %0d at %0b expected 2 0", floor, at_floor); end
    cmd(0, 0, 0, 0, 0);
    tick(3);
    n_cmp++; if (floor !== 4'd2 || at_floor !== 1'b0) begin n_err++; $display("FAIL rev_hold: got floor %0d at %0b expected 2 0", floor, at_floor); end
    pulses = 0;
    cmd(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin tick(1); if (reached) pulses++; end
    cmd(0, 0, 1, 0, 0);
    tick(1);
    n_cmp++; if (door_closed !== 1'b1 || at_floor !== 1'b0) begin n_err++; $display("FAIL rev_open_ignored: got closed %0b at %0b expected 1 0", door_closed, at_floor); end
    n_cmp++; if (fault !== FAULT_EXP) begin n_err++; $display("FAIL rev_open_fault: got %0b expected %0b", fault, FAULT_EXP); end
    cmd(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin tick(1); if (reached) pulses++; end
    n_cmp++; if (floor !== 4'd2 || at_floor !== 1'b1 || reached !== 1'b1) begin n_err++; $display("FAIL rev_return: got floor %0d at %0b reached %0b expected 2 1 1", floor, at_floor, reached); end
    cmd(0, 0, 0, 0, 0);
    tick(1);
    n_cmp++; if (pulses !== 1 || reached !== 1'b0) begin n_err++; $display("FAIL rev_pulses: got %0d (now %0b) expected 1 (0)", pulses, reached); end
  endtask

  task automatic test_illegal();
    do_reset();
    cmd(1, 0, 0, 0, 0);
    tick(16);
    cmd(1, 1, 0, 0, 0);
    tick(2);
    n_cmp++; if (floor !== 4'd1 || at_floor !== 1'b1) begin n_err++; $display("FAIL updown_hold: got floor %0d at %0b expected 1 1", floor, at_floor); end
    n_cmp++; if (fault !== FAULT_EXP) begin n_err++; $display("FAIL updown_fault: got %0b expected %0b", fault, FAULT_EXP); end
    cmd(0, 0, 0, 0, 0);
    tick(3);
    n_cmp++; if (fault !== FAULT_EXP) begin n_err++; $display("FAIL fault_sticky: got %0b expected %0b", fault, FAULT_EXP); end
    do_reset();
    cmd(0, 0, 1, 0, 0);
    tick(2);
    cmd(1, 0, 0, 0, 0);
    tick(3);
    n_cmp++; if (floor !== 4'd0 || at_floor !== 1'b1 || door_closed !== 1'b0) begin n_err++; $display("FAIL up_door_ajar: got floor %0d at %0b closed %0b expected 0 1 0", floor, at_floor, door_closed); end
    n_cmp++; if (fault !== FAULT_EXP) begin n_err++; $display("FAIL up_door_fault: got %0b expected %0b", fault, FAULT_EXP); end
    cmd(0, 0, 1, 1, 0);
    tick(2);
    n_cmp++; if (door_closed !== 1'b0 || door_open !== 1'b0) begin n_err++; $display("FAIL opcl_hold: got open %0b closed %0b expected 0 0", door_open, door_closed); end
    cmd(0, 0, 0, 1, 0);
    tick(2);
    n_cmp++; if (door_closed !== 1'b1) begin n_err++; $display("FAIL illegal_close: got %0b expected 1", door_closed); end
    do_reset();
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL fault_cleared: got %0b expected 0", fault); end
  endtask

  task automatic test_reset_midtravel();
    do_reset();
    cmd(1, 0, 0, 0, 0);
    tick(105);
    n_cmp++; if (floor !== 4'd6 || at_floor !== 1'b0) begin n_err++; $display("FAIL mid_pos: got floor %0d at %0b expected 6 0", floor, at_floor); end
    rst_n = 1'b0;
    tick(1);
    n_cmp++; if (floor !== 4'd0 || at_floor !== 1'b1 || reached !== 1'b0) begin n_err++; $display("FAIL mid_reset: got floor %0d at %0b reached %0b expected 0 1 0", floor, at_floor, reached); end
    n_cmp++; if (door_closed !== 1'b1 || door_open !== 1'b0 || obstacle !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL mid_reset_door: got closed %0b open %0b obs %0b fault %0b expected 1 0 0 0", door_closed, door_open, obstacle, fault); end
    rst_n = 1'b1;
    tick(15);
    n_cmp++; if (floor !== 4'd0 || at_floor !== 1'b0) begin n_err++; $display("FAIL mid_resume15: got floor %0d at %0b expected 0 0", floor, at_floor); end
    tick(1);
    n_cmp++; if (floor !== 4'd1 || reached !== 1'b1) begin n_err++; $display("FAIL mid_resume16: got floor %0d reached %0b expected 1 1", floor, reached); end
    cmd(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd(0, 0, 0, 0, 0);
    tick(2);
    test_reset();
    test_up_travel();
    test_down_travel();
    test_door();
    test_obstacle();
    test_reversal();
    test_illegal();
    test_reset_midtravel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
